// File: rtl/decompose_seq.sv
// Iterative binary-to-BCD converter (double dabble, one bit per clock) with
// per-digit tube pattern encoding, leading-zero blanking and overflow flag.
module decompose_seq #(
    parameter int IN_WIDTH = 21,
    parameter int DIGITS   = 8,
    parameter int SEG_BITS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [IN_WIDTH-1:0]          x,
    input  logic                         lz_blank,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow,
    output logic [4*DIGITS-1:0]          bcd_out,
    output logic [SEG_BITS*DIGITS-1:0]   seg_out
);

    localparam int CNT_W = $clog2(IN_WIDTH + 1);

    localparam logic [SEG_BITS-1:0] SEG_EMP   = SEG_BITS'(8'h00);
    localparam logic [SEG_BITS-1:0] SEG_ZERO  = SEG_BITS'(8'h3F);
    localparam logic [SEG_BITS-1:0] SEG_ONE   = SEG_BITS'(8'h06);
    localparam logic [SEG_BITS-1:0] SEG_TWO   = SEG_BITS'(8'h5B);
    localparam logic [SEG_BITS-1:0] SEG_THREE = SEG_BITS'(8'h4F);
    localparam logic [SEG_BITS-1:0] SEG_FOUR  = SEG_BITS'(8'h66);
    localparam logic [SEG_BITS-1:0] SEG_FIVE  = SEG_BITS'(8'h6D);
    localparam logic [SEG_BITS-1:0] SEG_SIX   = SEG_BITS'(8'h7D);
    localparam logic [SEG_BITS-1:0] SEG_SEVEN = SEG_BITS'(8'h07);
    localparam logic [SEG_BITS-1:0] SEG_EIGHT = SEG_BITS'(8'h7F);
    localparam logic [SEG_BITS-1:0] SEG_NINE  = SEG_BITS'(8'h6F);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        ENCODE = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [IN_WIDTH-1:0]          shift_q, shift_d;
    logic [4*DIGITS-1:0]          bcd_q, bcd_d;
    logic                         guard_q, guard_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         lz_q, lz_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         ovf_q, ovf_d;
    logic [4*DIGITS-1:0]          bcd_out_q, bcd_out_d;
    logic [SEG_BITS*DIGITS-1:0]   seg_out_q, seg_out_d;

    logic [4*DIGITS-1:0]          bcd_adj;
    logic [SEG_BITS*DIGITS-1:0]   seg_enc;
    logic [SEG_BITS*DIGITS-1:0]   seg_all_emp;

    function automatic logic [SEG_BITS-1:0] enc_digit(input logic [3:0] d);
        logic [SEG_BITS-1:0] p;
        case (d)
            4'd0:    p = SEG_ZERO;
            4'd1:    p = SEG_ONE;
            4'd2:    p = SEG_TWO;
            4'd3:    p = SEG_THREE;
            4'd4:    p = SEG_FOUR;
            4'd5:    p = SEG_FIVE;
            4'd6:    p = SEG_SIX;
            4'd7:    p = SEG_SEVEN;
            4'd8:    p = SEG_EIGHT;
            4'd9:    p = SEG_NINE;
            default: p = SEG_EMP;
        endcase
        return p;
    endfunction

    always_comb begin
        bcd_adj = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            else
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
        end
    end

    always_comb begin
        seg_all_emp = '0;
        for (int unsigned i = 0; i < DIGITS; i++)
            seg_all_emp[SEG_BITS*i +: SEG_BITS] = SEG_EMP;
    end

    // Walk from the top digit down; digits stay blank until the first nonzero
    // digit is met, and digit 0 always counts as significant.
    always_comb begin
        logic        seen;
        logic [3:0]  nib;
        int unsigned idx;
        seg_enc = '0;
        seen    = 1'b0;
        nib     = '0;
        idx     = 0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            idx = DIGITS - 1 - k;
            nib = bcd_q[4*idx +: 4];
            if (nib != 4'd0 || idx == 0)
                seen = 1'b1;
            if (lz_q && !seen)
                seg_enc[SEG_BITS*idx +: SEG_BITS] = SEG_EMP;
            else
                seg_enc[SEG_BITS*idx +: SEG_BITS] = enc_digit(nib);
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bcd_d     = bcd_q;
        guard_d   = guard_q;
        cnt_d     = cnt_q;
        lz_d      = lz_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        bcd_out_d = bcd_out_q;
        seg_out_d = seg_out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = x;
                    bcd_d   = '0;
                    guard_d = 1'b0;
                    cnt_d   = CNT_W'(IN_WIDTH);
                    lz_d    = lz_blank;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // {guard, bcd, shift} <<= 1 after the add-3 adjustment
                guard_d = guard_q | bcd_adj[4*DIGITS-1];
                if (DIGITS * 4 > 1)
                    bcd_d = {bcd_adj[4*DIGITS-2:0], shift_q[IN_WIDTH-1]};
                shift_d = {shift_q[IN_WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1))
                    state_d = ENCODE;
            end
            ENCODE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                ovf_d   = guard_q;
                if (guard_q) begin
                    bcd_out_d = '1;
                    seg_out_d = seg_all_emp;
                end else begin
                    bcd_out_d = bcd_q;
                    seg_out_d = seg_enc;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bcd_q     <= '0;
            guard_q   <= 1'b0;
            cnt_q     <= '0;
            lz_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            bcd_out_q <= '0;
            seg_out_q <= seg_all_emp;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bcd_q     <= bcd_d;
            guard_q   <= guard_d;
            cnt_q     <= cnt_d;
            lz_q      <= lz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            bcd_out_q <= bcd_out_d;
            seg_out_q <= seg_out_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign bcd_out  = bcd_out_q;
    assign seg_out  = seg_out_q;

endmodule

// File: tb/tb_decompose_seq.sv
// Directed bench for decompose_seq: default 8-digit instance plus a 4-digit
// instance sharing the same inputs to exercise overflow.
module tb_decompose_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [20:0] x;
    logic        lz_blank;

    logic        busy, done, overflow;
    logic [31:0] bcd_out;
    logic [63:0] seg_out;

    logic        busy4, done4, overflow4;
    logic [15:0] bcd_out4;
    logic [31:0] seg_out4;

    int tests = 0;
    int fails = 0;

    decompose_seq #(.IN_WIDTH(21), .DIGITS(8), .SEG_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .lz_blank(lz_blank),
        .busy(busy), .done(done), .overflow(overflow),
        .bcd_out(bcd_out), .seg_out(seg_out)
    );

    decompose_seq #(.IN_WIDTH(21), .DIGITS(4), .SEG_BITS(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .lz_blank(lz_blank),
        .busy(busy4), .done(done4), .overflow(overflow4),
        .bcd_out(bcd_out4), .seg_out(seg_out4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive start for one edge, then count edges until done (bounded).
    task automatic convert(input logic [20:0] val, input logic lz,
                           output int edges, output int busy_cycles);
        x = val;
        lz_blank = lz;
        start = 1'b1;
        tick;
        start = 1'b0;
        x = 21'h0AAAA;
        lz_blank = ~lz;
        busy_cycles = busy ? 1 : 0;
        edges = 0;
        while (!done && edges < 40) begin
            tick;
            edges++;
            if (busy) busy_cycles++;
        end
    endtask

    int e, bc;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        x = '0;
        lz_blank = 1'b0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_bcd", 64'(bcd_out), 64'd0);
        check("rst_seg", seg_out, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        convert(21'd1234567, 1'b0, e, bc);
        check("lat_1234567", 64'(e), 64'd22);
        check("bcd_1234567", 64'(bcd_out), 64'h01234567);
        check("seg_1234567", seg_out, 64'h3F065B4F666D7D07);
        check("ovf_1234567", 64'(overflow), 64'd0);
        check("ovf4_1234567", 64'(overflow4), 64'd1);
        check("bcd4_1234567", 64'(bcd_out4), 64'hFFFF);
        tick;
        check("done_1cyc", 64'(done), 64'd0);

        convert(21'd1234567, 1'b1, e, bc);
        check("seg_1234567_lz", seg_out, 64'h00065B4F666D7D07);
        check("bcd_1234567_lz", 64'(bcd_out), 64'h01234567);

        convert(21'd0, 1'b1, e, bc);
        check("seg_0_lz", seg_out, 64'h000000000000003F);
        check("bcd_0_lz", 64'(bcd_out), 64'h0);
        check("seg4_0_lz", 64'(seg_out4), 64'h0000003F);

        convert(21'd2097151, 1'b0, e, bc);
        check("bcd_max", 64'(bcd_out), 64'h02097151);
        check("seg_max", seg_out, 64'h3F5B3F6F07066D06);
        check("busy_max", 64'(bc), 64'd22);
        tick;
        check("done_max_1cyc", 64'(done), 64'd0);

        convert(21'd12345, 1'b0, e, bc);
        check("bcd_12345", 64'(bcd_out), 64'h00012345);
        check("ovf_12345", 64'(overflow), 64'd0);
        check("ovf4_12345", 64'(overflow4), 64'd1);
        check("bcd4_12345", 64'(bcd_out4), 64'hFFFF);
        check("seg4_12345", 64'(seg_out4), 64'h0);
        check("done4_12345", 64'(done4), 64'd1);

        convert(21'd9876, 1'b1, e, bc);
        check("ovf4_9876", 64'(overflow4), 64'd0);
        check("bcd4_9876", 64'(bcd_out4), 64'h9876);
        check("seg4_9876", 64'(seg_out4), 64'h6F7F077D);
        check("seg_9876_lz", seg_out, 64'h000000006F7F077D);

        // start re-asserted while busy must be ignored
        x = 21'd1234567;
        lz_blank = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        e = 0;
        repeat (5) begin tick; e++; end
        x = 21'd999;
        start = 1'b1;
        tick;
        e++;
        start = 1'b0;
        check("hold_bcd_midconv", 64'(bcd_out), 64'h00009876);
        while (!done && e < 40) begin tick; e++; end
        check("ign_lat", 64'(e), 64'd22);
        check("ign_bcd", 64'(bcd_out), 64'h01234567);

        // start in the done cycle is accepted immediately
        x = 21'd2097151;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("b2b_busy", 64'(busy), 64'd1);
        check("b2b_done_low", 64'(done), 64'd0);
        e = 0;
        while (!done && e < 40) begin tick; e++; end
        check("b2b_lat", 64'(e), 64'd22);
        check("b2b_bcd", 64'(bcd_out), 64'h02097151);

        // reset in the middle of SHIFT
        tick;
        x = 21'd1234567;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (8) tick;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_seg", seg_out, 64'h0);
        check("mid_rst_bcd", 64'(bcd_out), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bc = 0;
        repeat (30) begin
            tick;
            if (done) bc++;
        end
        check("mid_rst_nodone", 64'(bc), 64'd0);
        check("mid_rst_idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decompose_seq.md
Name: decompose_seq

Overview:
- Sequential, parametrised successor to the combinational digit splitter.
- Converts an unsigned binary value to BCD with an iterative shift-add-3 (double dabble) engine, one bit per clock, instead of divide/modulo chains.
- Encodes each digit to a tube segment pattern, with optional leading-zero blanking and overflow reporting.
- Sits between the arithmetic/result registers and the tube scan driver; uses start/busy/done handshaking.

Parameters:
- IN_WIDTH, 21 (`MAX_NUM): width of the binary input.
- DIGITS, 8: number of decimal digits produced, 1..10.
- SEG_BITS, 8 (`TUBE_BITS): width of one tube pattern.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request conversion of x; sampled only in IDLE.
- x  in  IN_WIDTH  unsigned binary value; captured on the accepted start edge.
- lz_blank  in  1  leading-zero blanking enable; captured with x.
- busy  out  1  high from the edge after accepted start until done.
- done  out  1  one-cycle pulse; seg_out/bcd_out/overflow valid from this cycle.
- overflow  out  1  x >= 10^DIGITS for the last conversion.
- bcd_out  out  4*DIGITS  packed BCD; digit i at [4i+3:4i], digit 0 is least significant.
- seg_out  out  SEG_BITS*DIGITS  tube patterns; digit i at [SEG_BITS*i+SEG_BITS-1:SEG_BITS*i].

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; busy=0, done=0, overflow=0, bcd_out=0.
  - Every seg_out digit = `emp; internal shift/BCD registers and bit counter cleared.
- FSM states IDLE -> SHIFT -> ENCODE -> IDLE:
  - IDLE: start=1 at an edge loads x, clears the BCD accumulator and overflow guard, sets the counter to IN_WIDTH, and goes to SHIFT. busy=1 from that edge.
  - SHIFT: each edge, every BCD nibble >= 5 gets +3, then {guard, bcd, shift} shifts left by one. The counter decrements; when it reaches 0, go to ENCODE.
  - ENCODE: one edge registers bcd_out, seg_out, overflow and done=1, clears busy, returns to IDLE.
- done is high for exactly one cycle: IN_WIDTH+1 edges after the start edge (22 at defaults).
- Outputs hold their values until the next ENCODE; they are not disturbed during a conversion.
- start while busy is ignored (no queuing).
- start in the same cycle as the done pulse is accepted, since the state is already IDLE; this gives back-to-back conversions.
- x and lz_blank may change freely after the accepted start edge.
- Overflow:
  - The guard flag is set if any bit is shifted out of the top nibble.
  - guard=1 gives overflow=1, every seg_out digit = `emp, and bcd_out = all-ones nibbles (4'hF).
- Encoding: nibble 0..9 maps to `zero..`nine; any other value maps to `emp.
- Leading-zero blanking, when lz_blank=1:
  - Zero digits above the most significant nonzero digit show `emp.
  - Digit 0 is never blanked (x=0 shows `zero).
  - bcd_out is unaffected by blanking.
- Reset mid-conversion aborts immediately to the reset values; no done pulse is produced.
- IN_WIDTH larger than needed for DIGITS is legal; overflow covers the excess.
- All arithmetic is unsigned, nibble-wise, with no cross-nibble carry beyond the shift.

Test Plan:
- Defaults, x=1234567, lz_blank=0 -> done at edge 22; bcd_out=32'h01234567; seg_out digits 7..0 = `zero,`one,`two,`three,`four,`five,`six,`seven; overflow=0.
- Same x, lz_blank=1 -> digit 7 = `emp, digits 6..0 unchanged.
- x=0, lz_blank=1 -> digit 0 = `zero, digits 7..1 = `emp.
- x=2097151 (max 21-bit) -> bcd_out=32'h02097151, busy high for 22 cycles, done for 1.
- DIGITS=4, x=12345 -> overflow=1, all four digits `emp, bcd_out=16'hFFFF.
- Handshake:
  - start re-asserted at cycle 5 of busy -> ignored; the result is for the original x.
  - start in the done cycle -> second conversion begins with no idle gap.
  - rst_n pulsed low mid-SHIFT -> busy=0, seg_out all `emp, no done.
